// File: rtl/project_pkg.sv
// rtl/project_pkg.sv - shared element type and string-id constants for the matrix sender path
package project_pkg;

    typedef logic [31:0] matrix_element_t;

    localparam logic [2:0] STR_ID_NONE   = 3'd0;
    localparam logic [2:0] STR_ID_PROMPT = 3'd1;
    localparam logic [2:0] STR_ID_RESULT = 3'd2;
    localparam logic [2:0] STR_ID_ERROR  = 3'd3;
    localparam logic [2:0] STR_ID_HEADER = 3'd4;

endpackage

// File: rtl/sender_arbiter_if.sv
// rtl/sender_arbiter_if.sv - requester-side command/handshake bundle shared by all arbiter ports
interface sender_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import project_pkg::*;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            p_start;
    logic [NUM_REQ-1:0]            p_str;
    logic [NUM_REQ-1:0]            p_newline_only;
    logic [NUM_REQ-1:0]            p_is_last_col;
    logic [NUM_REQ-1:0][2:0]       p_str_id;
    matrix_element_t [NUM_REQ-1:0] p_data;
    logic [NUM_REQ-1:0]            p_ready;
    logic [NUM_REQ-1:0]            p_done;
    logic                          p_timeout;

    modport master (
        output req, p_start, p_str, p_newline_only, p_is_last_col, p_str_id, p_data,
        input  p_ready, p_done, p_timeout
    );

    modport slave (
        input  req, p_start, p_str, p_newline_only, p_is_last_col, p_str_id, p_data,
        output p_ready, p_done, p_timeout
    );

endinterface

// File: rtl/sender_arbiter_rr_pick.sv
// rtl/sender_arbiter_rr_pick.sv - combinational round-robin picker, searches upward from rr_ptr+1
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   index_o,
    output logic               valid_o
);

    int idx;

    // Walk from farthest to nearest so the closest requester after rr_ptr wins.
    always_comb begin
        index_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (req_i[IDX_W'(idx)]) begin
                index_o = IDX_W'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sender_arbiter.sv
// rtl/sender_arbiter.sv - multiplexes NUM_REQ requesters onto one shared sender with session locking
module sender_arbiter
    import project_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 100_000_000,
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sender_arbiter_if.slave      req_if,
    output logic                 sender_start,
    output logic                 sender_str,
    output logic                 sender_newline_only,
    output logic                 sender_is_last_col,
    output logic [2:0]           sender_str_id,
    output matrix_element_t      sender_data,
    input  logic                 sender_ready,
    input  logic                 sender_done,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_id,
    output logic [7:0]           drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANTED,
        S_ISSUE,
        S_BUSY,
        S_DONE_PULSE
    } arb_state_e;

    arb_state_e      state_q, state_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [7:0]       drop_q, drop_d;
    logic             abort_q, abort_d;
    logic             start_q, start_d;
    logic             str_q, str_d;
    logic             nl_q, nl_d;
    logic             last_q, last_d;
    logic [2:0]       sid_q, sid_d;
    matrix_element_t  data_q, data_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] cmd;
    logic               accept;
    logic [9:0]         drop_inc;
    logic [9:0]         drop_sum;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i    (req_if.req),
        .rr_ptr_i (rr_ptr_q),
        .index_o  (pick_idx),
        .valid_o  (pick_valid)
    );

    assign cmd = req_if.p_start | req_if.p_str;

    always_comb begin
        state_d  = state_q;
        gid_d    = gid_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        abort_d  = abort_q;
        start_d  = start_q;
        str_d    = str_q;
        nl_d     = nl_q;
        last_d   = last_q;
        sid_d    = sid_q;
        data_d   = data_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANTED;
                    gid_d   = pick_idx;
                end
            end
            S_GRANTED: begin
                // Owner releasing takes priority over a same-cycle command.
                if (!req_if.req[gid_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = gid_q;
                end else if (cmd[gid_q] && sender_ready) begin
                    accept  = 1'b1;
                    start_d = req_if.p_start[gid_q];
                    str_d   = req_if.p_str[gid_q];
                    nl_d    = req_if.p_newline_only[gid_q];
                    last_d  = req_if.p_is_last_col[gid_q];
                    sid_d   = req_if.p_str_id[gid_q];
                    data_d  = req_if.p_data[gid_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                abort_d = 1'b0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (sender_done) begin
                    state_d = S_DONE_PULSE;
                end else if (wd_q + WD_W'(1) == WD_W'(TIMEOUT_CYCLES)) begin
                    state_d = S_DONE_PULSE;
                    abort_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_DONE_PULSE: begin
                wd_d = '0;
                if (req_if.req[gid_q]) begin
                    state_d = S_GRANTED;
                end else begin
                    state_d  = S_IDLE;
                    rr_ptr_d = gid_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every command pulse that was not the accepted one is counted.
        drop_inc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cmd[i] && !(accept && (IDX_W'(i) == gid_q))) begin
                drop_inc = drop_inc + 10'd1;
            end
        end
        drop_sum = {2'b00, drop_q} + drop_inc;
        drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gid_q    <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            wd_q     <= '0;
            drop_q   <= '0;
            abort_q  <= 1'b0;
            start_q  <= 1'b0;
            str_q    <= 1'b0;
            nl_q     <= 1'b0;
            last_q   <= 1'b0;
            sid_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            rr_ptr_q <= rr_ptr_d;
            wd_q     <= wd_d;
            drop_q   <= drop_d;
            abort_q  <= abort_d;
            start_q  <= start_d;
            str_q    <= str_d;
            nl_q     <= nl_d;
            last_q   <= last_d;
            sid_q    <= sid_d;
            data_q   <= data_d;
        end
    end

    logic [NUM_REQ-1:0] ready_vec;
    logic [NUM_REQ-1:0] done_vec;

    always_comb begin
        ready_vec = '0;
        done_vec  = '0;
        if (state_q == S_GRANTED) begin
            ready_vec[gid_q] = sender_ready;
        end
        if (state_q == S_DONE_PULSE) begin
            done_vec[gid_q] = 1'b1;
        end
    end

    assign req_if.p_ready       = ready_vec;
    assign req_if.p_done        = done_vec;
    assign req_if.p_timeout     = (state_q == S_DONE_PULSE) && abort_q;

    assign sender_start         = (state_q == S_ISSUE) && start_q;
    assign sender_str           = (state_q == S_ISSUE) && str_q;
    assign sender_newline_only  = nl_q;
    assign sender_is_last_col   = last_q;
    assign sender_str_id        = sid_q;
    assign sender_data          = data_q;
    assign grant_valid          = (state_q != S_IDLE);
    assign grant_id             = gid_q;
    assign drop_cnt             = drop_q;

endmodule
